// File: rtl/tl_pkg.sv
// tl_pkg: state encoding and lamp codes shared by the junction controller.
// Lamp bits: [5] veh red, [4] veh amber, [3] veh green, [2] ped red, [1] 0, [0] ped green.
package tl_pkg;
   typedef enum logic [2:0] {GREEN, AMBER, CROSS, CLEAR, FLASH} tl_state_e;
   localparam logic [5:0] G_R    = 6'b001100;
   localparam logic [5:0] A_R    = 6'b010100;
   localparam logic [5:0] R_G    = 6'b100001;
   localparam logic [5:0] RA_R   = 6'b110100;
   localparam logic [5:0] FL_ON  = 6'b010001;
   localparam logic [5:0] FL_OFF = 6'b000000;
endpackage

// File: rtl/tl_dwell_timer.sv
// tl_dwell_timer: 8-bit cycles-in-state counter that clears on state change,
// saturates at 255 and flags when the current state's dwell is complete.
module tl_dwell_timer (
   input  logic       clock,
   input  logic       reset,
   input  logic       clr,
   input  logic [7:0] limit,
   output logic       done
);
   logic [7:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? 8'd0 : (cnt_q == 8'hff ? cnt_q : cnt_q + 8'd1);
   always_ff @(posedge clock or negedge reset)
      if (!reset) cnt_q <= 8'hff;
      else cnt_q <= cnt_d;
   // Reset to 255 so a fresh controller treats minimum green as already served.
   assign done = cnt_q >= limit - 8'd1;
endmodule

// File: rtl/tl_junction_ctrl.sv
// tl_junction_ctrl: pedestrian-crossing junction sequencer.
// Define TL_FLASH_PHASE_EN to replace the red-amber CLEAR phase with a flashing FLASH phase.
module tl_junction_ctrl import tl_pkg::*; #(
   parameter int N_BTN     = 2,
   parameter int GREEN_MIN = 4,
   parameter int AMBER_T   = 1,
   parameter int CROSS_T   = 3,
   parameter int CLEAR_T   = 1,
   parameter int FLASH_T   = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_BTN-1:0] start,
   output logic [5:0]       lightseq,
   output logic             waiting
);
   if (N_BTN < 1 || GREEN_MIN < 1 || GREEN_MIN > 255 || AMBER_T < 1 || AMBER_T > 255 ||
       CROSS_T < 1 || CROSS_T > 255 || CLEAR_T < 1 || CLEAR_T > 255) begin : g_bad_param
      $fatal(1, "tl_junction_ctrl: illegal parameter value");
   end
`ifdef TL_FLASH_PHASE_EN
   if (FLASH_T < 1 || FLASH_T > 255) begin : g_bad_flash
      $fatal(1, "tl_junction_ctrl: illegal FLASH_T");
   end
`endif
   tl_state_e  state_q, state_d;
   logic       pending_q, pending_d;
   logic       any_start, done;
   logic [7:0] limit;
   assign any_start = |start;
   assign waiting   = pending_q;
   always_comb
      limit = state_q == AMBER ? 8'(AMBER_T) :
              state_q == CROSS ? 8'(CROSS_T) :
              state_q == CLEAR ? 8'(CLEAR_T) :
              state_q == FLASH ? 8'(FLASH_T) : 8'(GREEN_MIN);
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         GREEN:   state_d = (pending_q || any_start) && done ? AMBER : GREEN;
         AMBER:   state_d = done ? CROSS : AMBER;
`ifdef TL_FLASH_PHASE_EN
         CROSS:   state_d = done ? FLASH : CROSS;
`else
         CROSS:   state_d = done ? CLEAR : CROSS;
`endif
         default: state_d = done ? GREEN : state_q;
      endcase
      // A press on the very edge that serves the request must not be lost.
      pending_d = any_start || (pending_q && !(state_q == AMBER && state_d == CROSS));
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state_q   <= GREEN;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
`ifdef TL_FLASH_PHASE_EN
   logic phase_q, phase_d;
   always_comb phase_d = state_q == FLASH && state_d == FLASH && !phase_q;
   always_ff @(posedge clock or negedge reset)
      if (!reset) phase_q <= 1'b0;
      else phase_q <= phase_d;
`endif
   always_comb
      lightseq = state_q == AMBER ? A_R :
                 state_q == CROSS ? R_G :
                 state_q == CLEAR ? RA_R :
`ifdef TL_FLASH_PHASE_EN
                 state_q == FLASH ? (phase_q ? FL_OFF : FL_ON) :
`endif
                 G_R;
   tl_dwell_timer u_timer (
      .clock (clock),
      .reset (reset),
      .clr   (state_d != state_q),
      .limit (limit),
      .done  (done)
   );
endmodule

// File: tb/tb_tl_junction_ctrl.sv
// tb_tl_junction_ctrl: vector table, corner sequences and random stimulus for tl_junction_ctrl,
// checked against a queue-based model of the lamp sequence.
module tb_tl_junction_ctrl;
   localparam int GREEN_MIN = 4, AMBER_T = 1, CROSS_T = 3, CLEAR_T = 1, FLASH_T = 2;
   localparam logic [5:0] E_G = 6'b001100, E_A = 6'b010100, E_C = 6'b100001, E_RA = 6'b110100;
   localparam logic [5:0] E_FON = 6'b010001, E_FOFF = 6'b000000;
   logic       clock = 1'b0, reset = 1'b0;
   logic [1:0] start = 2'b00;
   logic [5:0] lightseq;
   logic       waiting;
   int         checks = 0, errors = 0;
   tl_junction_ctrl #(.N_BTN(2), .GREEN_MIN(GREEN_MIN), .AMBER_T(AMBER_T), .CROSS_T(CROSS_T),
                      .CLEAR_T(CLEAR_T), .FLASH_T(FLASH_T)) dut (
      .clock(clock), .reset(reset), .start(start), .lightseq(lightseq), .waiting(waiting));
   always #5 clock = ~clock;

   // Model: current lamp code, queue of the lamp codes still to come in a pedestrian
   // sequence, green cycles elapsed so far, and the request latch.
   logic [5:0] m_cur;
   logic [5:0] m_q[$];
   int         m_gcyc;
   bit         m_pend;

   task automatic m_reset();
      m_cur = E_G;
      m_q.delete();
      m_gcyc = 1000;
      m_pend = 1'b0;
   endtask

   task automatic m_step(input bit s);
      bit req = m_pend || s;
      if (s) m_pend = 1'b1;
      else if (m_cur == E_A && m_q.size() > 0 && m_q[0] == E_C) m_pend = 1'b0;
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else if (m_cur != E_G) begin
         m_cur = E_G;
         m_gcyc = 1;
      end else if (req && m_gcyc >= GREEN_MIN) begin
         m_cur = E_A;
         repeat (AMBER_T - 1) m_q.push_back(E_A);
         repeat (CROSS_T) m_q.push_back(E_C);
`ifdef TL_FLASH_PHASE_EN
         for (int i = 0; i < FLASH_T; i++) m_q.push_back(i % 2 ? E_FOFF : E_FON);
`else
         repeat (CLEAR_T) m_q.push_back(E_RA);
`endif
      end else if (m_gcyc < 1000) m_gcyc++;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic [1:0] s);
      start = s;
      @(posedge clock);
      m_step(|s);
      #1;
      chk("model_light", {2'b00, lightseq}, {2'b00, m_cur});
      chk("model_wait", {7'd0, waiting}, {7'd0, m_pend});
`ifdef TL_FLASH_PHASE_EN
      chk("no_clear_code", {7'd0, lightseq == E_RA}, 8'd0);
`endif
   endtask

   task automatic do_reset();
      start = 2'b00;
      reset = 1'b0;
      #1;
      m_reset();
      chk("reset_light", {2'b00, lightseq}, {2'b00, E_G});
      chk("reset_wait", {7'd0, waiting}, 8'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic mid_reset(input logic [1:0] s);
      start = s;
      reset = 1'b0;
      #1;
      m_reset();
      chk("async_reset_light", {2'b00, lightseq}, {2'b00, E_G});
      chk("async_reset_wait", {7'd0, waiting}, 8'd0);
      #1;
      reset = 1'b1;
   endtask

   typedef struct { logic [1:0] s; logic [5:0] light; logic w; } vec_t;
   vec_t tbl[20];

   initial begin
      int run;
      tbl[0]  = '{2'b01, E_A, 1'b1};  tbl[1]  = '{2'b00, E_C, 1'b0};
      tbl[2]  = '{2'b00, E_C, 1'b0};  tbl[3]  = '{2'b00, E_C, 1'b0};
      tbl[4]  = '{2'b00, E_RA, 1'b0}; tbl[5]  = '{2'b00, E_G, 1'b0};
      tbl[6]  = '{2'b00, E_G, 1'b0};  tbl[7]  = '{2'b00, E_G, 1'b0};
      tbl[8]  = '{2'b00, E_G, 1'b0};  tbl[9]  = '{2'b10, E_A, 1'b1};
      tbl[10] = '{2'b00, E_C, 1'b0};  tbl[11] = '{2'b01, E_C, 1'b1};
      tbl[12] = '{2'b00, E_C, 1'b1};  tbl[13] = '{2'b00, E_RA, 1'b1};
      tbl[14] = '{2'b00, E_G, 1'b1};  tbl[15] = '{2'b00, E_G, 1'b1};
      tbl[16] = '{2'b00, E_G, 1'b1};  tbl[17] = '{2'b00, E_G, 1'b1};
      tbl[18] = '{2'b00, E_A, 1'b1};  tbl[19] = '{2'b00, E_C, 1'b0};
      do_reset();
`ifndef TL_FLASH_PHASE_EN
      for (int i = 0; i < 20; i++) begin
         cyc(tbl[i].s);
         chk("tbl_light", {2'b00, lightseq}, {2'b00, tbl[i].light});
         chk("tbl_wait", {7'd0, waiting}, {7'd0, tbl[i].w});
      end
`else
      cyc(2'b01);
      chk("fl_amber", {2'b00, lightseq}, {2'b00, E_A});
      repeat (3) cyc(2'b00);
      chk("fl_cross", {2'b00, lightseq}, {2'b00, E_C});
      cyc(2'b00);
      chk("fl_on", {2'b00, lightseq}, {2'b00, E_FON});
      cyc(2'b00);
      chk("fl_off", {2'b00, lightseq}, {2'b00, E_FOFF});
      cyc(2'b00);
      chk("fl_green", {2'b00, lightseq}, {2'b00, E_G});
`endif
      // Multi-button presses must behave like a single press.
      for (int p = 0; p < 2; p++) begin
         do_reset();
         for (int i = 0; i < 14; i++) cyc(i == 0 ? (p == 0 ? 2'b11 : 2'b10) : 2'b00);
      end
      // Reset mid-CROSS with a request held through it.
      do_reset();
      cyc(2'b01);
      cyc(2'b00);
      chk("in_cross", {2'b00, lightseq}, {2'b00, E_C});
      mid_reset(2'b01);
      cyc(2'b01);
      chk("amber_after_reset", {2'b00, lightseq}, {2'b00, E_A});
      // Held request: endless cycle with exactly GREEN_MIN green cycles between sequences.
      do_reset();
      run = 0;
      for (int i = 0; i < 45; i++) begin
         cyc(2'b01);
         chk("held_wait", {7'd0, waiting}, 8'd1);
         if (lightseq == E_G) run++;
         else if (run > 0) begin
            chk("held_green_run", 8'(run), 8'(GREEN_MIN));
            run = 0;
         end
      end
      // Random presses with occasional asynchronous resets.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 60) == 0) mid_reset(2'($urandom_range(0, 3)));
         cyc($urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
